gpow_pipe: RTL and testbench

- Parametrised modular-exponentiation engine: the successor to the fixed-q square-and-multiply unit used in key generation.
- Computes a^b mod Q (mode 0), or the modular inverse a^(Q-2) mod Q (mode 1, Fermat).
- Uses a valid/ready handshake on both input and output.
- Contains its own fully pipelined modular multiplier (DSP multiply + Barrett) and issues res*a and a*a back-to-back into it, so each exponent bit costs one pipeline pass rather than two.

---
 rtl/gpow_pipe_if.sv | 25 ++
 rtl/gpow_pipe.sv | 191 +++++++++++++++++++
 tb/tb_gpow_pipe.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/gpow_pipe_if.sv
// Request/result handshake bundle for the gpow_pipe modular-exponentiation engine.
interface gpow_pipe_if #(
  parameter int WIDTH     = 24,
  parameter int EXP_WIDTH = 24
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 mode;
  logic [WIDTH-1:0]     a;
  logic [EXP_WIDTH-1:0] b;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     res;
  logic                 busy;

  modport master (
    output in_valid, mode, a, b, out_ready,
    input  in_ready, out_valid, res, busy
  );

  modport slave (
    input  in_valid, mode, a, b, out_ready,
    output in_ready, out_valid, res, busy
  );
endinterface

// File: rtl/gpow_pipe.sv
// Square-and-multiply modular exponentiation (a^b or a^(Q-2) mod Q) with a private
// pipelined Barrett multiplier; res*a and a*a are issued back-to-back each exponent bit.
module gpow_pipe #(
  parameter int          WIDTH     = 24,
  parameter int          EXP_WIDTH = 24,
  parameter int unsigned Q         = 8380417,
  parameter int unsigned MU        = 33587228,
  parameter int          MUL_LAT   = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  gpow_pipe_if.slave bus
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE0 = 3'd1;
  localparam logic [2:0] S_ISSUE1 = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_RES  = 2'd1;
  localparam logic [1:0] TAG_SQ   = 2'd2;

  localparam int PW = 2 * WIDTH;
  localparam int XW = 2 * WIDTH + 4;
  localparam int CW = $clog2(MUL_LAT + 1);

  localparam logic [WIDTH-1:0]     Q_W   = WIDTH'(Q);
  localparam logic [XW-1:0]        Q_X   = XW'(Q);
  localparam logic [XW-1:0]        MU_X  = XW'(MU);
  localparam logic [EXP_WIDTH-1:0] QM2_E = EXP_WIDTH'(Q - 32'd2);

  logic [2:0]           state_r;
  logic [WIDTH-1:0]     cur_a_r;
  logic [EXP_WIDTH-1:0] cur_b_r;
  logic [WIDTH-1:0]     cur_res_r;
  logic [WIDTH-1:0]     res_r;
  logic                 out_valid_r;
  logic                 busy_r;
  logic [CW-1:0]        wait_cnt_r;

  logic [WIDTH-1:0]     a_red_s;
  logic [WIDTH-1:0]     mul_op1_s;
  logic [WIDTH-1:0]     mul_op2_s;
  logic [1:0]           issue_tag_s;
  logic [1:0]           tag_out_s;
  logic [WIDTH-1:0]     mul_out_s;

  logic [PW-1:0]        prod_r;
  logic [PW-1:0]        prod1_r;
  logic [XW-1:0]        t_r;
  logic [1:0]           tag_r [0:MUL_LAT-1];

  logic [XW-1:0]        qmu_s;
  logic [XW-1:0]        tq_s;
  logic [XW-1:0]        rem_s;
  logic [XW-1:0]        rem1_s;
  logic [XW-1:0]        rem2_s;
  logic [WIDTH-1:0]     red_s;

  assign a_red_s       = (bus.a >= Q_W) ? (bus.a - Q_W) : bus.a;
  assign bus.in_ready  = (state_r == S_IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.res       = res_r;
  assign bus.busy      = busy_r;

  // Barrett reduction: the estimate t is at most two short, so r lands in [0, 3Q).
  assign qmu_s  = XW'(prod_r >> (WIDTH - 1)) * MU_X;
  assign tq_s   = t_r * Q_X;
  assign rem_s  = XW'(prod1_r) - tq_s;
  assign rem1_s = (rem_s >= Q_X) ? (rem_s - Q_X) : rem_s;
  assign rem2_s = (rem1_s >= Q_X) ? (rem1_s - Q_X) : rem1_s;
  assign red_s  = WIDTH'(rem2_s);

  assign tag_out_s = tag_r[MUL_LAT-1];

  // Issue-slot selection: multiply slot in ISSUE0, square slot in ISSUE1, bubble otherwise
  always_comb begin
    mul_op1_s   = '0;
    mul_op2_s   = '0;
    issue_tag_s = TAG_NONE;
    case (state_r)
      S_ISSUE0: begin
        if ((cur_b_r != '0) && cur_b_r[0]) begin
          mul_op1_s   = cur_res_r;
          mul_op2_s   = cur_a_r;
          issue_tag_s = TAG_RES;
        end else begin
          issue_tag_s = TAG_NONE;
        end
      end
      S_ISSUE1: begin
        if ((cur_b_r >> 1) != '0) begin
          mul_op1_s   = cur_a_r;
          mul_op2_s   = cur_a_r;
          issue_tag_s = TAG_SQ;
        end else begin
          issue_tag_s = TAG_NONE;
        end
      end
      default: issue_tag_s = TAG_NONE;
    endcase
  end

  // Multiplier front stages and the tag shift register that travels alongside them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_r  <= '0;
      prod1_r <= '0;
      t_r     <= '0;
      for (int i = 0; i < MUL_LAT; i++) tag_r[i] <= TAG_NONE;
    end else begin
      prod_r   <= PW'(mul_op1_s) * PW'(mul_op2_s);
      prod1_r  <= prod_r;
      t_r      <= qmu_s >> (WIDTH + 1);
      tag_r[0] <= issue_tag_s;
      for (int i = 1; i < MUL_LAT; i++) tag_r[i] <= tag_r[i-1];
    end
  end

  // Pad the reduced product so it emerges exactly MUL_LAT edges after issue.
  if (MUL_LAT > 2) begin : g_dly
    logic [WIDTH-1:0] dly_r [0:MUL_LAT-3];

    // Result delay line
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < MUL_LAT - 2; i++) dly_r[i] <= '0;
      end else begin
        dly_r[0] <= red_s;
        for (int i = 1; i < MUL_LAT - 2; i++) dly_r[i] <= dly_r[i-1];
      end
    end

    assign mul_out_s = dly_r[MUL_LAT-3];
  end else begin : g_nodly
    assign mul_out_s = red_s;
  end

  // Control FSM plus tag-driven capture of products into the accumulator and base
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      cur_a_r     <= '0;
      cur_b_r     <= '0;
      cur_res_r   <= '0;
      res_r       <= '0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      wait_cnt_r  <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (bus.in_valid) begin
            cur_a_r   <= a_red_s;
            cur_b_r   <= bus.mode ? QM2_E : bus.b;
            cur_res_r <= WIDTH'(1);
            busy_r    <= 1'b1;
            state_r   <= S_ISSUE0;
          end
        end
        S_ISSUE0: state_r <= (cur_b_r == '0) ? S_DONE : S_ISSUE1;
        S_ISSUE1: begin
          wait_cnt_r <= CW'(MUL_LAT - 1);
          state_r    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt_r == '0) begin
            cur_b_r <= cur_b_r >> 1;
            state_r <= S_ISSUE0;
          end else begin
            wait_cnt_r <= wait_cnt_r - CW'(1);
          end
        end
        S_DONE: begin
          if (!out_valid_r) begin
            res_r       <= cur_res_r;
            out_valid_r <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= S_IDLE;
          end
        end
        default: state_r <= S_IDLE;
      endcase
      if (tag_out_s == TAG_RES) cur_res_r <= mul_out_s;
      if (tag_out_s == TAG_SQ)  cur_a_r   <= mul_out_s;
    end
  end
endmodule

// File: tb/tb_gpow_pipe.sv
// Bench for gpow_pipe: directed cases, backpressure, reset abort and a random sweep,
// each result scored against a square-and-multiply reference with latency checking.
module tb_gpow_pipe;
  localparam int W  = 24;
  localparam int EW = 24;
  localparam int ML = 5;
  localparam longint unsigned QM = 64'd8380417;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc     = 0;
  int   checks  = 0;
  int   errors  = 0;
  int   acc_cyc = 0;
  logic [W-1:0] exp_q [$];
  int           lat_q [$];
  logic [W-1:0] held_res;
  logic         rm;
  logic [W-1:0] ra;
  logic [EW-1:0] rb;
  int           rlen;

  gpow_pipe_if #(.WIDTH(W), .EXP_WIDTH(EW)) bus ();

  gpow_pipe #(
    .WIDTH(W), .EXP_WIDTH(EW), .Q(32'd8380417), .MU(32'd33587228), .MUL_LAT(ML)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] ref_pow(input logic m, input logic [W-1:0] av,
                                           input logic [EW-1:0] bv);
    longint unsigned base, r, e;
    base = av;
    base = base % QM;
    if (m) e = QM - 64'd2;
    else   e = bv;
    r = 64'd1;
    while (e != 64'd0) begin
      if (e[0]) r = (r * base) % QM;
      base = (base * base) % QM;
      e = e >> 1;
    end
    return r[W-1:0];
  endfunction

  function automatic int bit_len(input logic m, input logic [EW-1:0] bv);
    longint unsigned e;
    int n;
    if (m) e = QM - 64'd2;
    else   e = bv;
    n = 0;
    while (e != 64'd0) begin
      n++;
      e = e >> 1;
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic note_accept(input logic m, input logic [W-1:0] av, input logic [EW-1:0] bv);
    acc_cyc = cyc;
    exp_q.push_back(ref_pow(m, av, bv));
    lat_q.push_back(2 + bit_len(m, bv) * (ML + 2));
  endtask

  // Present a request, wait for the accept edge, then scramble the inputs.
  task automatic send(input string tag, input logic m, input logic [W-1:0] av,
                      input logic [EW-1:0] bv);
    int n;
    bus.mode = m; bus.a = av; bus.b = bv; bus.in_valid = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 400) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_accept_wait"}, 64'(n < 400), 64'd1);
    @(posedge clk); #1;
    note_accept(m, av, bv);
    bus.in_valid = 1'b0;
    bus.a = W'($urandom);
    bus.b = EW'($urandom);
    bus.mode = 1'($urandom);
    check({tag, "_busy_after_accept"}, 64'(bus.busy), 64'd1);
    check({tag, "_in_ready_after_accept"}, 64'(bus.in_ready), 64'd0);
  endtask

  task automatic await_out(input string tag);
    int n;
    int lat;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 400) begin
      @(posedge clk); #1; n++;
    end
    lat = lat_q.pop_front();
    check({tag, "_latency"}, 64'(cyc - acc_cyc), 64'(lat));
  endtask

  task automatic take(input string tag);
    check({tag, "_res"}, 64'(bus.res), 64'(exp_q.pop_front()));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_out_valid_drop"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_busy_drop"}, 64'(bus.busy), 64'd0);
  endtask

  task automatic run(input string tag, input logic m, input logic [W-1:0] av,
                     input logic [EW-1:0] bv);
    send(tag, m, av, bv);
    await_out(tag);
    take(tag);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.mode = 1'b0;
    bus.a = '0; bus.b = '0;
    #2;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_res", 64'(bus.res), 64'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    run("pow3_5", 1'b0, 24'd3, 24'd5);
    check("pow3_5_value", 64'(bus.res), 64'd243);
    run("pow2_23", 1'b0, 24'd2, 24'd23);
    check("pow2_23_value", 64'(bus.res), 64'd8191);
    run("inv2", 1'b1, 24'd2, 24'h000123);
    check("inv2_value", 64'(bus.res), 64'd4190209);
    run("inv_qm1", 1'b1, 24'd8380416, 24'd0);
    run("inv0", 1'b1, 24'd0, 24'd9);
    run("zero_zero", 1'b0, 24'd0, 24'd0);
    check("zero_zero_value", 64'(bus.res), 64'd1);
    run("a_eq_q", 1'b0, 24'd8380417, 24'd7);
    run("qm1_sq", 1'b0, 24'd8380416, 24'd2);
    check("qm1_sq_value", 64'(bus.res), 64'd1);

    // Backpressure with a pending second request
    send("bp1", 1'b0, 24'd7, 24'd10);
    bus.out_ready = 1'b0;
    await_out("bp1");
    held_res = bus.res;
    bus.mode = 1'b0; bus.a = 24'd3; bus.b = 24'd5; bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
      check("bp_hold_res", 64'(bus.res), 64'(held_res));
      check("bp_hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    check("bp1_res", 64'(bus.res), 64'(exp_q.pop_front()));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_handoff_valid", 64'(bus.out_valid), 64'd0);
    check("bp_handoff_not_accepted", 64'(bus.busy), 64'd0);
    check("bp_handoff_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    note_accept(1'b0, 24'd3, 24'd5);
    bus.in_valid = 1'b0;
    check("bp2_accepted", 64'(bus.busy), 64'd1);
    await_out("bp2");
    take("bp2");

    // Reset in the middle of a long run
    send("abort", 1'b0, 24'd12345, 24'hFFFFFF);
    repeat (12) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_in_ready", 64'(bus.in_ready), 64'd1);
    check("abort_out_valid", 64'(bus.out_valid), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_res", 64'(bus.res), 64'd0);
    exp_q.delete();
    lat_q.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    run("post_abort", 1'b0, 24'd5, 24'd3);
    check("post_abort_value", 64'(bus.res), 64'd125);

    for (int i = 0; i < 1000; i++) begin
      rm = ($urandom_range(31, 0) == 0);
      ra = W'($urandom_range(8380416, 0));
      if ($urandom_range(31, 0) == 0) begin
        rb = EW'($urandom);
      end else begin
        rlen = $urandom_range(12, 0);
        rb = EW'($urandom) & ((24'd1 << rlen) - 24'd1);
      end
      run("rnd", rm, ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
